// File: rtl/cpu_mem_ctrl.sv
// cpu_mem_ctrl: two-state CPU bus controller decoding RAM, WRAM and banked PRG storage,
// with one-cycle ack after each accepted request.
module cpu_mem_ctrl #(
    parameter int PRG_BANK_BITS = 1,
    parameter bit WRAM_EN = 1'b1,
    parameter logic [7:0] INVALID_DATA = 8'hCD
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic wr,
    input  logic [15:0] addr,
    input  logic [7:0] din,
    input  logic rom_wp,
    output logic [7:0] dout,
    output logic ack,
    output logic invalid_req,
    output logic busy,
    output logic [PRG_BANK_BITS-1:0] prg_bank
);
    localparam int PRG_AW = 14 + PRG_BANK_BITS;
    typedef enum logic {IDLE, ACCESS} state_t;
    typedef enum logic [1:0] {R_RAM, R_WRAM, R_PRG, R_NONE} region_t;
    state_t state, state_nx;
    region_t region, region_q;
    logic wr_q, accept;
    logic [PRG_AW-1:0] prg_addr;
    logic [7:0] ram_q, wram_q, prg_q;
    logic [7:0] ram [0:2047];
    logic [7:0] prg [0:(1<<PRG_AW)-1];
    always_comb begin
        region = addr[15] ? R_PRG : addr[15:13] == 3'b000 ? R_RAM :
                 (addr[15:13] == 3'b011 && WRAM_EN) ? R_WRAM : R_NONE;
        prg_addr = {addr[14] ? {PRG_BANK_BITS{1'b1}} : prg_bank, addr[13:0]};
        accept = !rst && state == IDLE && req;
        state_nx = accept ? ACCESS : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prg_bank <= '0;
        end else begin
            state <= state_nx;
            if (accept && wr && rom_wp && region == R_PRG)
                prg_bank <= din[PRG_BANK_BITS-1:0];
        end
        if (accept) begin
            wr_q <= wr;
            region_q <= region;
        end
    end
    // Storage is read at the accepting edge so data is ready during the ack cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            if (wr && region == R_RAM) ram[addr[10:0]] <= din;
            ram_q <= ram[addr[10:0]];
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            if (wr && !rom_wp && region == R_PRG) prg[prg_addr] <= din;
            prg_q <= prg[prg_addr];
        end
    end
    generate
        if (WRAM_EN) begin : g_wram
            logic [7:0] wram [0:8191];
            always_ff @(posedge clk) begin
                if (accept) begin
                    if (wr && region == R_WRAM) wram[addr[12:0]] <= din;
                    wram_q <= wram[addr[12:0]];
                end
            end
        end else begin : g_no_wram
            assign wram_q = 8'h00;
        end
    endgenerate
    always_comb begin
        busy = state == ACCESS;
        ack = busy && !rst;
        invalid_req = ack && region_q == R_NONE;
        dout = !ack ? 8'h00 : region_q == R_NONE ? INVALID_DATA : wr_q ? 8'h00 :
               region_q == R_RAM ? ram_q : region_q == R_WRAM ? wram_q : prg_q;
    end
endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// tb_cpu_mem_ctrl: directed vectors, held-req and reset corner cases, then random
// accesses checked against an address-range memory model.
module tb_cpu_mem_ctrl;
    logic clk = 0, rst = 1, req = 0, wr = 0, rom_wp = 1;
    logic [15:0] addr = 0;
    logic [7:0] din = 0;
    logic [7:0] dout, dout0;
    logic ack, ack0, inv, inv0, busy, busy0;
    logic [0:0] bank;
    logic [1:0] bank0;
    int compared = 0, mismatched = 0;

    cpu_mem_ctrl dut (.clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .din(din),
        .rom_wp(rom_wp), .dout(dout), .ack(ack), .invalid_req(inv), .busy(busy), .prg_bank(bank));
    cpu_mem_ctrl #(.PRG_BANK_BITS(2), .WRAM_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .req(req),
        .wr(wr), .addr(addr), .din(din), .rom_wp(rom_wp), .dout(dout0), .ack(ack0),
        .invalid_req(inv0), .busy(busy0), .prg_bank(bank0));

    always #5 clk = ~clk;

    typedef struct {
        logic w; logic [15:0] a; logic [7:0] d; logic wp;
        logic [7:0] ed; logic ei; logic eb; bit c0;
    } vec_t;
    vec_t tv[15];

    bit [7:0] m_ram[2048], m_wram[8192], m_prg[32768];
    bit v_ram[2048], v_wram[8192], v_prg[32768];
    int m_bank = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leaves the bench at the negedge inside the ACCESS cycle
    task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d, input logic wp);
        wr = w; addr = a; din = d; rom_wp = wp; req = 1;
        @(posedge clk);
        @(negedge clk);
        req = 0;
    endtask

    task automatic idle_chk();
        @(posedge clk);
        @(negedge clk);
        chk("idle_ack", ack, 0);
        chk("idle_dout", dout, 0);
        chk("idle_inv", inv, 0);
    endtask

    task automatic model(input logic w, input logic [15:0] a, input logic [7:0] d, input logic wp,
                         output logic [7:0] ed, output bit known, output logic ei);
        int off;
        known = 1; ei = 0; ed = 8'h00;
        if (a < 16'h2000) begin
            off = a % 2048;
            if (w) begin m_ram[off] = d; v_ram[off] = 1; end
            else begin ed = m_ram[off]; known = v_ram[off]; end
        end else if (a < 16'h6000) begin
            ei = 1; ed = 8'hCD;
        end else if (a < 16'h8000) begin
            off = a - 16'h6000;
            if (w) begin m_wram[off] = d; v_wram[off] = 1; end
            else begin ed = m_wram[off]; known = v_wram[off]; end
        end else begin
            off = (a >= 16'hC000 ? 1 : m_bank) * 16384 + a % 16384;
            if (w && wp) m_bank = d % 2;
            else if (w) begin m_prg[off] = d; v_prg[off] = 1; end
            else begin ed = m_prg[off]; known = v_prg[off]; end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ed;
        logic ei;
        bit known;
        tv[0]  = '{1'b1, 16'h0123, 8'h55, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 16'h1923, 8'h00, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 16'h8000, 8'hA1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 16'hC000, 8'hB2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 16'h8000, 8'h00, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 16'hC000, 8'h00, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 16'h8000, 8'h01, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 16'h8000, 8'h00, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 16'hC000, 8'h00, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 16'h2002, 8'h00, 1'b1, 8'hCD, 1'b1, 1'b1, 1'b1};
        tv[10] = '{1'b1, 16'h3FFF, 8'h77, 1'b1, 8'hCD, 1'b1, 1'b1, 1'b1};
        tv[11] = '{1'b1, 16'h6000, 8'h5A, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        tv[12] = '{1'b0, 16'h6000, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1};
        tv[13] = '{1'b1, 16'h0800, 8'h66, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        tv[14] = '{1'b0, 16'h1800, 8'h00, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0};

        req = 1;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dout", dout, 0);
        chk("rst_inv", inv, 0);
        chk("rst_bank", bank, 0);
        req = 0; rst = 0;
        @(negedge clk);

        foreach (tv[k]) begin
            issue(tv[k].w, tv[k].a, tv[k].d, tv[k].wp);
            chk($sformatf("vec%0d_ack", k), ack, 1);
            chk($sformatf("vec%0d_busy", k), busy, 1);
            chk($sformatf("vec%0d_dout", k), dout, tv[k].ed);
            chk($sformatf("vec%0d_inv", k), inv, tv[k].ei);
            chk($sformatf("vec%0d_bank", k), bank, tv[k].eb);
            if (tv[k].c0) begin
                chk($sformatf("vec%0d_nowram_dout", k), dout0, 8'hCD);
                chk($sformatf("vec%0d_nowram_inv", k), inv0, 1);
            end
            idle_chk();
        end

        wr = 0; addr = 16'h0123; rom_wp = 1; req = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 5) req = 0;
            chk($sformatf("held%0d_ack", i), ack, (i % 2 == 0));
            chk($sformatf("held%0d_busy", i), busy, (i % 2 == 0));
            chk($sformatf("held%0d_dout", i), dout, (i % 2 == 0) ? 8'h55 : 8'h00);
        end
        @(negedge clk);

        wr = 1; addr = 16'h0456; din = 8'h99; req = 1;
        @(posedge clk);
        #1 rst = 1; req = 0;
        @(negedge clk);
        chk("rstacc_ack", ack, 0);
        chk("rstacc_dout", dout, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("rstacc_busy", busy, 0);
        chk("rstacc_bank", bank, 0);
        chk("rstacc_ack2", ack, 0);
        issue(0, 16'h0456, 8'h00, 1);
        chk("rstacc_kept", dout, 8'h99);
        idle_chk();
        issue(0, 16'h8000, 8'h00, 1);
        chk("rstacc_bank0_rd", dout, 8'hA1);
        idle_chk();

        m_bank = 0;
        for (int n = 0; n < 400; n++) begin
            logic w, wp;
            logic [15:0] a;
            logic [7:0] d;
            w = 1'($urandom);
            wp = ($urandom_range(0, 3) != 0);
            a = 16'($urandom) & 16'hFC07;
            d = 8'($urandom);
            model(w, a, d, wp, ed, known, ei);
            issue(w, a, d, wp);
            chk($sformatf("rnd%0d_ack", n), ack, 1);
            chk($sformatf("rnd%0d_inv", n), inv, ei);
            if (known) chk($sformatf("rnd%0d_dout@%0h", n, a), dout, ed);
            chk($sformatf("rnd%0d_bank", n), bank, m_bank);
            idle_chk();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
